// File: rtl/mac_seq_ctrl.sv
// +--------------------------------------------------------------------------+
// | mac_seq_ctrl : FIFO -> IMEM -> ALU MAC burst sequencer with timeout      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module mac_seq_ctrl #(
  parameter int SHIFT_CYCLES = 1,
  parameter int BURST_LEN    = 4,
  parameter int TO_W         = 8,
  parameter int CNT_W        = 16,
  localparam int IDX_W       = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             continuous,
  input  logic             abort,
  input  logic             clear_err,
  input  logic [TO_W-1:0]  timeout_limit,
  input  logic             fifo_empty,
  input  logic             mac_done,
  output logic             read_enable,
  output logic             shift_enable,
  output logic             start_mac,
  output logic             done,
  output logic             busy,
  output logic             timeout_err,
  output logic [IDX_W-1:0] sample_idx,
  output logic [CNT_W-1:0] job_count
);

  localparam int SC_W = (SHIFT_CYCLES > 1) ? $clog2(SHIFT_CYCLES) : 1;
  localparam logic [SC_W-1:0]  SC_LAST  = SC_W'(SHIFT_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BURST_LEN - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_READ  = 3'd2;
  localparam logic [2:0] S_SHIFT = 3'd3;
  localparam logic [2:0] S_START = 3'd4;
  localparam logic [2:0] S_WAIT  = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;
  localparam logic [2:0] S_ERR   = 3'd7;

  logic [2:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [SC_W-1:0]  sc_q, sc_d;
  logic [TO_W-1:0]  to_q, to_d;
  logic [CNT_W-1:0] jc_q, jc_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    sc_d    = sc_q;
    to_d    = to_q;
    jc_d    = jc_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          idx_d   = '0;
        end
      end
      S_FETCH: begin
        if (!fifo_empty) state_d = S_READ;
      end
      S_READ: begin
        state_d = S_SHIFT;
        sc_d    = '0;
      end
      S_SHIFT: begin
        if (sc_q == SC_LAST) begin
          if (idx_q == IDX_LAST) begin
            state_d = S_START;
          end else begin
            state_d = S_FETCH;
            idx_d   = idx_q + IDX_W'(1);
          end
        end else begin
          sc_d = sc_q + SC_W'(1);
        end
      end
      S_START: begin
        state_d = S_WAIT;
        to_d    = '0;
      end
      S_WAIT: begin
        // mac_done takes priority over a timeout expiring in the same cycle
        if (mac_done) begin
          state_d = S_DONE;
        end else if ((timeout_limit != '0) && (to_q == timeout_limit - TO_W'(1))) begin
          state_d = S_ERR;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end
      S_DONE: begin
        jc_d = jc_q + CNT_W'(1);
        if (continuous) begin
          state_d = S_FETCH;
          idx_d   = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ERR: begin
        if (clear_err) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort overrides every transition; the job counter is deliberately kept.
    if (abort && (state_q != S_IDLE) && (state_q != S_ERR)) begin
      state_d = S_IDLE;
      idx_d   = '0;
      sc_d    = '0;
      to_d    = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      sc_q    <= '0;
      to_q    <= '0;
      jc_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sc_q    <= sc_d;
      to_q    <= to_d;
      jc_q    <= jc_d;
    end
  end

  assign read_enable  = (state_q == S_READ);
  assign shift_enable = (state_q == S_SHIFT);
  assign start_mac    = (state_q == S_START);
  assign done         = (state_q == S_DONE);
  assign busy         = (state_q != S_IDLE);
  assign timeout_err  = (state_q == S_ERR);
  assign sample_idx   = idx_q;
  assign job_count    = jc_q;

endmodule

`default_nettype wire

// File: tb/tb_mac_seq_ctrl.sv
// +--------------------------------------------------------------------------+
// | tb_mac_seq_ctrl : directed self-checking bench for mac_seq_ctrl          |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_mac_seq_ctrl;

  logic        clk;
  logic        reset;
  logic        start;
  logic        continuous;
  logic        abort;
  logic        clear_err;
  logic [7:0]  timeout_limit;
  logic        fifo_empty;
  logic        mac_done;
  logic        read_enable;
  logic        shift_enable;
  logic        start_mac;
  logic        done;
  logic        busy;
  logic        timeout_err;
  logic [1:0]  sample_idx;
  logic [15:0] job_count;

  int checks = 0;
  int errors = 0;

  mac_seq_ctrl #(
    .SHIFT_CYCLES(2),
    .BURST_LEN   (3),
    .TO_W        (8),
    .CNT_W       (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .continuous   (continuous),
    .abort        (abort),
    .clear_err    (clear_err),
    .timeout_limit(timeout_limit),
    .fifo_empty   (fifo_empty),
    .mac_done     (mac_done),
    .read_enable  (read_enable),
    .shift_enable (shift_enable),
    .start_mac    (start_mac),
    .done         (done),
    .busy         (busy),
    .timeout_err  (timeout_err),
    .sample_idx   (sample_idx),
    .job_count    (job_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] strobes();
    return {read_enable, shift_enable, start_mac, done};
  endfunction

  // One job from IDLE; cycle 0 is the cycle in which start is sampled.
  // stall: FIFO empty during cycles 5..9 shifts later events by 5.
  // mac_c < 0: mac_done never arrives in WAIT (timeout path, ERR from 19).
  task automatic run_job(input int s, input int mac_c, input int ncyc);
    logic rd, sh, sm, dn, bz, te;
    for (int c = 0; c < ncyc; c++) begin
      start      = (c == 0) || (c == 5);
      fifo_empty = (s != 0) && (c >= 5) && (c <= 9);
      mac_done   = (c == mac_c) || ((mac_c < 0) && (c >= 19) && (c <= 21));
      abort      = (mac_c < 0) && (c == 22);
      rd = (c == 2) || (c == 6 + s) || (c == 10 + s);
      sh = (c == 3) || (c == 4) || (c == 7 + s) || (c == 8 + s) ||
           (c == 11 + s) || (c == 12 + s);
      sm = (c == 13 + s);
      dn = (mac_c >= 0) && (c == mac_c + 1);
      bz = (mac_c >= 0) ? ((c >= 1) && (c <= mac_c + 1)) : (c >= 1);
      te = (mac_c < 0) && (c >= 19 + s);
      check($sformatf("job_strobes_c%0d", c), 32'(strobes()), 32'({rd, sh, sm, dn}));
      check($sformatf("job_busy_c%0d", c), 32'(busy), 32'(bz));
      check($sformatf("job_terr_c%0d", c), 32'(timeout_err), 32'(te));
      if (c == 7 + s)  check("job_idx_second", 32'(sample_idx), 32'd1);
      if (c == 11 + s) check("job_idx_third", 32'(sample_idx), 32'd2);
      step();
    end
    start      = 1'b0;
    fifo_empty = 1'b0;
    mac_done   = 1'b0;
    abort      = 1'b0;
  endtask

  initial begin
    logic [3:0] es;
    int p;
    reset = 1'b1; start = 1'b0; continuous = 1'b0; abort = 1'b0;
    clear_err = 1'b0; timeout_limit = 8'd0; fifo_empty = 1'b0; mac_done = 1'b0;

    #2;
    check("reset_strobes", 32'(strobes()), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_terr", 32'(timeout_err), 32'd0);
    check("reset_idx", 32'(sample_idx), 32'd0);
    check("reset_jobcnt", 32'(job_count), 32'd0);
    step();
    reset = 1'b0;

    // Single job, no stall, no timeout
    run_job(0, 17, 21);
    check("single_jobcnt", 32'(job_count), 32'd1);

    // FIFO stall of 5 cycles
    run_job(5, 22, 26);
    check("stall_jobcnt", 32'(job_count), 32'd2);

    // Timeout into ERR, then clear_err
    timeout_limit = 8'd5;
    run_job(0, -1, 25);
    clear_err = 1'b1;
    check("err_held_terr", 32'(timeout_err), 32'd1);
    check("err_held_busy", 32'(busy), 32'd1);
    step();
    clear_err = 1'b0;
    check("err_cleared_terr", 32'(timeout_err), 32'd0);
    check("err_cleared_busy", 32'(busy), 32'd0);
    check("err_jobcnt", 32'(job_count), 32'd2);

    // mac_done on the last allowed WAIT cycle wins over timeout
    run_job(0, 18, 21);
    check("tie_jobcnt", 32'(job_count), 32'd3);
    check("tie_terr", 32'(timeout_err), 32'd0);
    timeout_limit = 8'd0;

    // Async reset while in WAIT
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (13) step();
    check("areset_pre_busy", 32'(busy), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("areset_busy", 32'(busy), 32'd0);
    check("areset_strobes", 32'(strobes()), 32'd0);
    check("areset_jobcnt", 32'(job_count), 32'd0);
    check("areset_idx", 32'(sample_idx), 32'd0);
    #1 reset = 1'b0;
    mac_done = 1'b1;
    step();
    check("areset_late_done1", 32'(done), 32'd0);
    step();
    mac_done = 1'b0;
    check("areset_late_done2", 32'(done), 32'd0);
    check("areset_late_busy", 32'(busy), 32'd0);
    step();

    // Continuous mode: two back-to-back jobs, then abort in SHIFT (cycle 35)
    continuous = 1'b1;
    for (int c = 0; c <= 40; c++) begin
      if (c == 0 || c > 35) p = 0;
      else if (c > 32)      p = c - 32;
      else if (c > 16)      p = c - 16;
      else                  p = c;
      start    = (c == 0);
      mac_done = (p == 15);
      abort    = (c == 35);
      es = {(p == 2) || (p == 6) || (p == 10),
            (p == 3) || (p == 4) || (p == 7) || (p == 8) || (p == 11) || (p == 12),
            (p == 13),
            (p == 16)};
      check($sformatf("cont_strobes_c%0d", c), 32'(strobes()), 32'(es));
      check($sformatf("cont_busy_c%0d", c), 32'(busy), 32'((c >= 1) && (c <= 35)));
      if (c == 16) check("cont_idx_done", 32'(sample_idx), 32'd2);
      if (c == 17) check("cont_idx_restart", 32'(sample_idx), 32'd0);
      if (c == 17) check("cont_jobcnt1", 32'(job_count), 32'd1);
      if (c == 33) check("cont_jobcnt2", 32'(job_count), 32'd2);
      if (c == 36) check("abort_idx", 32'(sample_idx), 32'd0);
      step();
    end
    start = 1'b0; mac_done = 1'b0; abort = 1'b0; continuous = 1'b0;
    check("abort_jobcnt", 32'(job_count), 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mac_seq_ctrl.md
# mac_seq_ctrl

Parametrised single-clock sequencer for the FIFO → IMEM → ALU MAC datapath. It fetches a configurable burst of samples from the FIFO read side and shifts each sample into IMEM for a configurable number of cycles. It then launches one MAC operation and waits for completion under a programmable timeout. It adds single-shot and continuous modes, abort, sticky timeout error, and progress counters.

## Interface
- SHIFT_CYCLES, default 1: shift_enable cycles per sample read (≥1).
- BURST_LEN, default 4: samples read per MAC job (≥1).
- TO_W, default 8: width of timeout_limit and timeout counter.
- CNT_W, default 16: width of job_count.
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high; all state and outputs cleared immediately.
- start  in  1  launch a job; sampled only in IDLE.
- continuous  in  1  after DONE, go to FETCH instead of IDLE; sampled in DONE.
- abort  in  1  synchronous abort; from any state except IDLE/ERR → IDLE next cycle.
- clear_err  in  1  in ERR → IDLE next cycle; ignored elsewhere.
- timeout_limit  in  TO_W  max WAIT cycles; 0 disables the timeout.
- fifo_empty  in  1  FIFO empty flag.
- mac_done  in  1  ALU MAC completion; honoured only in WAIT.
- read_enable  out  1  FIFO read strobe.
- shift_enable  out  1  IMEM shift strobe.
- start_mac  out  1  MAC launch strobe.
- done  out  1  one-cycle job-complete pulse.
- busy  out  1  high when state ≠ IDLE.
- timeout_err  out  1  sticky; high in ERR.
- sample_idx  out  clog2(BURST_LEN) (min 1)  current sample within burst.
- job_count  out  CNT_W  completed jobs, wraps modulo 2^CNT_W.

## Operation
- States: IDLE, FETCH, READ, SHIFT, START, WAIT, DONE, ERR. All outputs are Moore decodes of the state register plus counters; no extra output register stage.
- IDLE: start=1 → FETCH, sample_idx←0. Otherwise stay.
- FETCH: fifo_empty=0 → READ; else stall with no strobes.
- READ: read_enable=1 for exactly 1 cycle → SHIFT, shift counter←0.
- SHIFT: shift_enable=1 for SHIFT_CYCLES consecutive cycles.
  - Last cycle with sample_idx==BURST_LEN-1 → START.
  - Last cycle otherwise → FETCH, sample_idx+1.
- START: start_mac=1 for 1 cycle → WAIT, timeout counter←0.
- WAIT: mac_done=1 → DONE. Else if timeout_limit≠0 and counter==timeout_limit-1 → ERR. Else counter+1.
- DONE: done=1 for 1 cycle, job_count+1 (wraps).
  - continuous=1 → FETCH, sample_idx←0.
  - continuous=0 → IDLE.
- ERR: timeout_err=1 and busy=1. start and mac_done are ignored. clear_err → IDLE.

## Timing
- Reset values: read_enable, shift_enable, start_mac, done, busy, timeout_err = 0; sample_idx = 0; job_count = 0; state = IDLE.
- Per sample with FIFO non-empty: FETCH 1 + READ 1 + SHIFT SHIFT_CYCLES cycles.
- Job overhead: START 1 cycle, WAIT ≥1 cycle, DONE 1 cycle.
- mac_done in the same cycle as timeout expiry: mac_done wins → DONE, no error.
- mac_done outside WAIT: ignored, not remembered.
- start while busy: ignored.
- abort together with mac_done in WAIT: abort wins → IDLE, no done pulse, job_count unchanged.
- abort clears sample_idx and the shift and timeout counters. job_count is kept.
- Strobes (read_enable, shift_enable, start_mac, done) are mutually exclusive in every cycle.
- Async reset mid-job: outputs drop to reset values without waiting for a clock edge; no done pulse.

## Test plan
Common setup: SHIFT_CYCLES=2, BURST_LEN=3, TO_W=8. Cycle n = state after clock edge n; start sampled at edge 0.
- Reset: assert reset between edges → all outputs 0 immediately, state IDLE, busy=0.
- Single job: fifo_empty=0, start pulse, mac_done high in cycle 17, continuous=0 →
  - read_enable in cycles 2, 6, 10.
  - shift_enable in cycles 3-4, 7-8, 11-12.
  - start_mac in cycle 13.
  - done in cycle 18; job_count=1; busy=0 from cycle 19.
- FIFO stall: fifo_empty=1 during cycles 5-9 of the single-job run → FETCH held; second read_enable in cycle 11; all later events shift by +5.
- Timeout: timeout_limit=5, mac_done never asserted → ERR after the 5th WAIT cycle, timeout_err=1 and held. Then clear_err → IDLE, timeout_err=0. Repeat with mac_done on the 5th WAIT cycle → done=1, timeout_err=0.
- Continuous: continuous=1, one start pulse, mac_done 2 cycles after each start_mac → back-to-back jobs; job_count reaches 2 after the second done, sample_idx restarts at 0. Then abort during SHIFT → IDLE next cycle, no further strobes, job_count stays 2.
- Async reset in WAIT: busy drops immediately; a later mac_done produces no done pulse; job_count=0.
